// File: rtl/cam_cfg_sequencer.sv
// Camera sensor configuration sequencer: walks a register table after power-up and issues
// I2C writes with retry, a post-software-reset settle delay, and done/error reporting.
module cam_cfg_sequencer #(
  parameter int unsigned POWERUP_CYCLES     = 2500000,
  parameter int unsigned RESET_DELAY_CYCLES = 250000,
  parameter int unsigned LUT_SIZE           = 255,
  parameter int unsigned MAX_RETRY          = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [9:0]  lut_index,
  input  logic [31:0] lut_data,
  input  logic        i2c_addr_2byte,
  output logic        i2c_write_req,
  output logic [7:0]  i2c_slave_addr,
  output logic [15:0] i2c_register_addr,
  output logic [7:0]  i2c_write_data,
  input  logic        i2c_write_req_ack,
  input  logic        i2c_error,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error
);

  typedef enum logic [2:0] {
    StPowerup,
    StFetch,
    StReq,
    StWaitAck,
    StDelay,
    StDone,
    StError
  } state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_cnt, r_retry;
  logic [9:0]  r_lut_index;
  logic        r_req;
  logic [7:0]  r_slave;
  logic [15:0] r_reg_addr;
  logic [7:0]  r_data;

  logic [31:0] w_cnt_inc, w_retry_inc;
  logic [15:0] w_reg_addr;
  logic        w_seq_end, w_ack_seen, w_sw_reset, w_at_last;

  assign w_cnt_inc   = r_cnt + 32'd1;
  assign w_retry_inc = r_retry + 32'd1;
  assign w_at_last   = (r_lut_index == 10'(LUT_SIZE));
  assign w_seq_end   = w_at_last || (lut_data[31:24] == 8'hff);
  assign w_ack_seen  = (r_state == StWaitAck) && i2c_write_req_ack;
  assign w_reg_addr  = i2c_addr_2byte ? lut_data[23:8] : {8'h00, lut_data[15:8]};
  // Sensor software reset needs a settle time before the next write.
  assign w_sw_reset  = (r_reg_addr == 16'h3008) && r_data[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StPowerup;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StPowerup: if (w_cnt_inc >= POWERUP_CYCLES) w_state_next = StFetch;
      StFetch:   w_state_next = w_seq_end ? StDone : StReq;
      StReq:     w_state_next = StWaitAck;
      StWaitAck: begin
        if (w_ack_seen) begin
          if (!i2c_error) begin
            w_state_next = w_sw_reset ? StDelay : StFetch;
          end else begin
            // Going through FETCH gives exactly one low clock before the retry.
            w_state_next = (w_retry_inc >= MAX_RETRY) ? StError : StFetch;
          end
        end
      end
      StDelay:   if (w_cnt_inc >= RESET_DELAY_CYCLES) w_state_next = StFetch;
      StDone,
      StError:   if (start) w_state_next = StFetch;
      default:   w_state_next = StPowerup;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_retry     <= '0;
      r_lut_index <= '0;
      r_req       <= 1'b0;
      r_slave     <= '0;
      r_reg_addr  <= '0;
      r_data      <= '0;
    end else begin
      r_req <= (w_state_next == StReq) || (w_state_next == StWaitAck);

      if (((r_state == StPowerup) || (r_state == StDelay)) && (w_state_next == r_state)) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= '0;
      end

      if ((r_state == StFetch) && (w_state_next == StReq)) begin
        r_slave    <= lut_data[31:24];
        r_reg_addr <= w_reg_addr;
        r_data     <= lut_data[7:0];
      end

      if (w_ack_seen) begin
        if (!i2c_error) begin
          r_retry <= '0;
          if ((w_state_next == StFetch) && !w_at_last) r_lut_index <= r_lut_index + 10'd1;
        end else begin
          r_retry <= w_retry_inc;
        end
      end

      if ((r_state == StDelay) && (w_state_next == StFetch) && !w_at_last) begin
        r_lut_index <= r_lut_index + 10'd1;
      end

      if (((r_state == StDone) || (r_state == StError)) && start) begin
        r_lut_index <= '0;
        r_retry     <= '0;
      end
    end
  end

  always_comb begin
    cfg_busy  = 1'b1;
    cfg_done  = 1'b0;
    cfg_error = 1'b0;
    case (r_state)
      StDone: begin
        cfg_busy = 1'b0;
        cfg_done = 1'b1;
      end
      StError: begin
        cfg_busy  = 1'b0;
        cfg_error = 1'b1;
      end
      default: ;
    endcase
  end

  assign lut_index         = r_lut_index;
  assign i2c_write_req     = r_req;
  assign i2c_slave_addr    = r_slave;
  assign i2c_register_addr = r_reg_addr;
  assign i2c_write_data    = r_data;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer: an I2C responder acks each request 5 clocks after it
// rises (optionally with NACKs) and logs every write for the scenario tasks to check.
module tb_cam_cfg_sequencer;

  localparam int P = 10;
  localparam int D = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  lut_index;
  logic [31:0] lut_data;
  logic        i2c_addr_2byte = 1'b1;
  logic        i2c_write_req;
  logic [7:0]  i2c_slave_addr;
  logic [15:0] i2c_register_addr;
  logic [7:0]  i2c_write_data;
  logic        i2c_write_req_ack;
  logic        i2c_error;
  logic        cfg_busy, cfg_done, cfg_error;

  logic        resp_ack = 1'b0;
  logic        resp_err = 1'b0;
  logic        tb_ack = 1'b0;
  logic [31:0] tb_lut [4];

  int cyc = 0;
  int nasserts = 0;
  int nfail = 0;
  int rel_cyc = 0;
  int nack_index = -1;
  int nack_left = 0;

  logic [7:0]  q_slave [$];
  logic [15:0] q_reg [$];
  logic [7:0]  q_data [$];
  int          q_rise [$];
  int          q_ack [$];
  bit          q_after [$];
  bit          q_stable [$];

  logic [15:0] exp_seq_reg [4] = '{16'h3103, 16'h3008, 16'h4300, 16'h5001};
  logic [7:0]  exp_seq_dat [4] = '{8'h11, 8'h82, 8'h60, 8'ha3};
  int          exp_gap [3] = '{2, 22, 2};
  logic [15:0] exp_rty_reg [6] = '{16'h3103, 16'h3008, 16'h4300, 16'h4300, 16'h4300, 16'h5001};

  assign i2c_write_req_ack = resp_ack | tb_ack;
  assign i2c_error = resp_err;
  assign lut_data = (lut_index < 10'd4) ? tb_lut[lut_index[1:0]] : 32'h0;

  cam_cfg_sequencer #(
    .POWERUP_CYCLES    (P),
    .RESET_DELAY_CYCLES(D),
    .LUT_SIZE          (4),
    .MAX_RETRY         (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .lut_index        (lut_index),
    .lut_data         (lut_data),
    .i2c_addr_2byte   (i2c_addr_2byte),
    .i2c_write_req    (i2c_write_req),
    .i2c_slave_addr   (i2c_slave_addr),
    .i2c_register_addr(i2c_register_addr),
    .i2c_write_data   (i2c_write_data),
    .i2c_write_req_ack(i2c_write_req_ack),
    .i2c_error        (i2c_error),
    .cfg_busy         (cfg_busy),
    .cfg_done         (cfg_done),
    .cfg_error        (cfg_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit          r_prev = 1'b0;
  bit          r_abort, r_stab;
  int          r_idx, r_k;
  logic [7:0]  r_s, r_d;
  logic [15:0] r_r;

  initial begin : responder
    forever begin
      @(posedge clk);
      #1;
      if (i2c_write_req && !r_prev) begin
        r_s = i2c_slave_addr;
        r_r = i2c_register_addr;
        r_d = i2c_write_data;
        r_idx = int'(lut_index);
        q_slave.push_back(r_s);
        q_reg.push_back(r_r);
        q_data.push_back(r_d);
        q_rise.push_back(cyc);
        r_abort = 1'b0;
        r_stab = 1'b1;
        r_k = 0;
        while (!r_abort && r_k < 4) begin
          @(posedge clk);
          #1;
          r_k++;
          if (!i2c_write_req) r_abort = 1'b1;
          else if (i2c_slave_addr !== r_s || i2c_register_addr !== r_r || i2c_write_data !== r_d)
            r_stab = 1'b0;
        end
        if (!r_abort) begin
          q_ack.push_back(cyc);
          resp_ack = 1'b1;
          if (nack_left > 0 && r_idx == nack_index) begin
            resp_err = 1'b1;
            nack_left--;
          end
          @(posedge clk);
          #1;
          resp_ack = 1'b0;
          resp_err = 1'b0;
          q_after.push_back(i2c_write_req);
          q_stable.push_back(r_stab);
        end
      end
      r_prev = i2c_write_req;
    end
  end

  task automatic clear_logs();
    q_slave.delete(); q_reg.delete(); q_data.delete(); q_rise.delete();
    q_ack.delete(); q_after.delete(); q_stable.delete();
  endtask

  task automatic load_default();
    tb_lut[0] = 32'h7831_0311;
    tb_lut[1] = 32'h7830_0882;
    tb_lut[2] = 32'h7843_0060;
    tb_lut[3] = 32'h7850_01a3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (cfg_done || cfg_error) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    nasserts++;
    if ({lut_index, i2c_write_req, i2c_slave_addr, i2c_register_addr, i2c_write_data} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: idx=%h req=%b slv=%h reg=%h dat=%h, want all zero",
               lut_index, i2c_write_req, i2c_slave_addr, i2c_register_addr, i2c_write_data);
    end
    nasserts++;
    if ({cfg_busy, cfg_done, cfg_error} !== 3'b100) begin
      nfail++;
      $display("FAIL reset_flags: busy/done/err=%b, want 100", {cfg_busy, cfg_done, cfg_error});
    end
    do_reset();
    repeat (3) @(negedge clk);
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    nasserts++;
    if ({cfg_busy, i2c_write_req, lut_index} !== {1'b1, 1'b0, 10'd0}) begin
      nfail++;
      $display("FAIL powerup_ack_ignored: busy=%b req=%b idx=%0d, want 1 0 0",
               cfg_busy, i2c_write_req, lut_index);
    end
  endtask

  task automatic test_sequence();
    bit ok;
    load_default();
    i2c_addr_2byte = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish(400, ok);
    nasserts++;
    if (!ok) begin nfail++; $display("FAIL seq_timeout: finished=%b want 1", ok); end
    nasserts++;
    if (q_reg.size() != 4 || q_ack.size() != 4) begin
      nfail++;
      $display("FAIL seq_count: writes=%0d acks=%0d, want 4 4", q_reg.size(), q_ack.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nasserts++;
        if (q_slave[i] !== 8'h78 || q_reg[i] !== exp_seq_reg[i] || q_data[i] !== exp_seq_dat[i]
            || q_after[i] !== 1'b0 || q_stable[i] !== 1'b1) begin
          nfail++;
          $display("FAIL seq_write%0d: %h/%h/%h after=%b stable=%b, want 78/%h/%h after=0 stable=1",
                   i, q_slave[i], q_reg[i], q_data[i], q_after[i], q_stable[i],
                   exp_seq_reg[i], exp_seq_dat[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        nasserts++;
        if (q_rise[i+1] - q_ack[i] != exp_gap[i]) begin
          nfail++;
          $display("FAIL seq_gap%0d: %0d clocks, want %0d", i, q_rise[i+1] - q_ack[i], exp_gap[i]);
        end
      end
      nasserts++;
      if (q_rise[0] - rel_cyc != P + 1) begin
        nfail++;
        $display("FAIL powerup_latency: %0d clocks, want %0d", q_rise[0] - rel_cyc, P + 1);
      end
    end
    nasserts++;
    if ({cfg_done, cfg_error, cfg_busy} !== 3'b100 || lut_index !== 10'd4) begin
      nfail++;
      $display("FAIL seq_final: done/err/busy=%b idx=%0d, want 100 idx=4",
               {cfg_done, cfg_error, cfg_busy}, lut_index);
    end
    @(negedge clk);
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    repeat (2) @(negedge clk);
    nasserts++;
    if (cfg_done !== 1'b1 || lut_index !== 10'd4 || i2c_write_req !== 1'b0) begin
      nfail++;
      $display("FAIL done_ack_ignored: done=%b idx=%0d req=%b, want 1 4 0",
               cfg_done, lut_index, i2c_write_req);
    end
  endtask

  task automatic test_early_end();
    bit ok;
    load_default();
    tb_lut[2] = 32'hff00_0000;
    do_reset();
    wait_finish(400, ok);
    nasserts++;
    if (!ok || q_reg.size() != 2 || cfg_done !== 1'b1 || lut_index !== 10'd2) begin
      nfail++;
      $display("FAIL early_end: finished=%b writes=%0d done=%b idx=%0d, want 1 2 1 2",
               ok, q_reg.size(), cfg_done, lut_index);
    end
  endtask

  task automatic test_retry();
    bit ok;
    load_default();
    nack_index = 2;
    nack_left = 2;
    do_reset();
    wait_finish(500, ok);
    nasserts++;
    if (!ok || q_reg.size() != 6 || q_ack.size() != 6) begin
      nfail++;
      $display("FAIL retry_count: finished=%b writes=%0d, want 1 6", ok, q_reg.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        nasserts++;
        if (q_reg[i] !== exp_rty_reg[i] || q_slave[i] !== 8'h78) begin
          nfail++;
          $display("FAIL retry_write%0d: %h/%h, want 78/%h", i, q_slave[i], q_reg[i], exp_rty_reg[i]);
        end
      end
      nasserts++;
      if (q_data[2] !== 8'h60 || q_data[3] !== 8'h60 || q_data[4] !== 8'h60) begin
        nfail++;
        $display("FAIL retry_data: %h %h %h, want 60 60 60", q_data[2], q_data[3], q_data[4]);
      end
      nasserts++;
      if (q_rise[3] - q_ack[2] != 2 || q_rise[4] - q_ack[3] != 2) begin
        nfail++;
        $display("FAIL retry_gap: %0d %0d, want 2 2", q_rise[3] - q_ack[2], q_rise[4] - q_ack[3]);
      end
    end
    nasserts++;
    if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || lut_index !== 10'd4) begin
      nfail++;
      $display("FAIL retry_final: done=%b err=%b idx=%0d, want 1 0 4", cfg_done, cfg_error, lut_index);
    end
    nack_left = 0;
  endtask

  task automatic test_abort();
    bit ok;
    load_default();
    nack_index = 2;
    nack_left = 3;
    do_reset();
    wait_finish(500, ok);
    nasserts++;
    if (!ok || {cfg_error, cfg_done, cfg_busy} !== 3'b100 || lut_index !== 10'd2) begin
      nfail++;
      $display("FAIL abort_final: finished=%b err/done/busy=%b idx=%0d, want 1 100 2",
               ok, {cfg_error, cfg_done, cfg_busy}, lut_index);
    end
    repeat (30) @(posedge clk);
    #1;
    nasserts++;
    if (q_reg.size() != 5 || i2c_write_req !== 1'b0 || cfg_error !== 1'b1) begin
      nfail++;
      $display("FAIL abort_quiet: writes=%0d req=%b err=%b, want 5 0 1",
               q_reg.size(), i2c_write_req, cfg_error);
    end
    nack_left = 0;
    nack_index = -1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    load_default();
    do_reset();
    n = 0;
    while (q_rise.size() < 1 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    nasserts++;
    if (i2c_write_req !== 1'b0 || lut_index !== 10'd0 || cfg_busy !== 1'b1 || q_ack.size() != 0) begin
      nfail++;
      $display("FAIL mid_reset: req=%b idx=%0d busy=%b acks=%0d, want 0 0 1 0",
               i2c_write_req, lut_index, cfg_busy, q_ack.size());
    end
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_finish(400, ok);
    nasserts++;
    if (!ok || q_rise.size() != 4 || cfg_done !== 1'b1) begin
      nfail++;
      $display("FAIL mid_reset_rerun: finished=%b writes=%0d done=%b, want 1 4 1",
               ok, q_rise.size(), cfg_done);
    end else begin
      nasserts++;
      if (q_rise[0] - rel_cyc != P + 1) begin
        nfail++;
        $display("FAIL mid_reset_powerup: %0d clocks, want %0d", q_rise[0] - rel_cyc, P + 1);
      end
    end
  endtask

  task automatic test_one_byte_restart();
    bit ok;
    int s_cyc;
    tb_lut[0] = 32'h7800_1234;
    tb_lut[1] = 32'h78ab_5678;
    tb_lut[2] = 32'hff00_0000;
    tb_lut[3] = 32'h0;
    i2c_addr_2byte = 1'b0;
    do_reset();
    wait_finish(400, ok);
    nasserts++;
    if (!ok || q_reg.size() != 2) begin
      nfail++;
      $display("FAIL one_byte_count: finished=%b writes=%0d, want 1 2", ok, q_reg.size());
    end else begin
      nasserts++;
      if (q_reg[0] !== 16'h0012 || q_data[0] !== 8'h34 || q_reg[1] !== 16'h0056 || q_data[1] !== 8'h78)
      begin
        nfail++;
        $display("FAIL one_byte_fields: %h/%h %h/%h, want 0012/34 0056/78",
                 q_reg[0], q_data[0], q_reg[1], q_data[1]);
      end
    end
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc + 1;
    clear_logs();
    @(negedge clk);
    start = 1'b0;
    nasserts++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b1 || lut_index !== 10'd0) begin
      nfail++;
      $display("FAIL restart_clear: done=%b busy=%b idx=%0d, want 0 1 0", cfg_done, cfg_busy, lut_index);
    end
    wait_finish(100, ok);
    nasserts++;
    if (!ok || q_rise.size() != 2 || cfg_done !== 1'b1 || lut_index !== 10'd2) begin
      nfail++;
      $display("FAIL restart_rerun: finished=%b writes=%0d done=%b idx=%0d, want 1 2 1 2",
               ok, q_rise.size(), cfg_done, lut_index);
    end else begin
      nasserts++;
      if (q_rise[0] - s_cyc != 1) begin
        nfail++;
        $display("FAIL restart_latency: %0d clocks after start, want 1", q_rise[0] - s_cyc);
      end
    end
    i2c_addr_2byte = 1'b1;
  endtask

  initial begin
    load_default();
    test_reset();
    test_sequence();
    test_early_end();
    test_retry();
    test_abort();
    test_reset_mid();
    test_one_byte_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule
